// File: rtl/counter_burst_scheduler_pkg.sv
// Shared types, default widths and the round-robin pick rule for counter_burst_scheduler.
package counter_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_LEN_W   = 8;
  localparam int MAX_REQ     = 16;
  localparam int PICK_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sched_state_e;

  // First set bit strictly after 'last', wrapping at 'num'; returns 0 when nothing is pending.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [PICK_W-1:0]  last,
                                                input int                 num);
    logic [PICK_W-1:0] pick;
    logic              found;
    int                idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % num;
      if (k <= num && !found && req[idx[PICK_W-1:0]]) begin
        pick  = idx[PICK_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/counter_burst_scheduler_if.sv
// Requester, counter and tagged-output signals of counter_burst_scheduler.
// CSCHED_STATS_EN adds the stat_bursts/stat_beats counters.
interface counter_burst_scheduler_if import counter_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     ctr_ready;
  logic                     ctr_valid;
  logic [DATA_W-1:0]        ctr_count;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [ID_W-1:0]          out_id;
  logic                     busy;
`ifdef CSCHED_STATS_EN
  logic [31:0]              stat_bursts;
  logic [31:0]              stat_beats;
`endif

  modport slave (
    input  req, req_len, ctr_valid, ctr_count,
    output grant, done, ctr_ready, out_valid, out_data, out_id, busy
`ifdef CSCHED_STATS_EN
    , output stat_bursts, stat_beats
`endif
  );

  modport master (
    output req, req_len, ctr_valid, ctr_count,
    input  grant, done, ctr_ready, out_valid, out_data, out_id, busy
`ifdef CSCHED_STATS_EN
    , input stat_bursts, stat_beats
`endif
  );

endinterface

// File: rtl/counter_burst_scheduler_rr_arbiter.sv
// Combinational round-robin pick over the request vector; the pointer only moves when
// the scheduler accepts the pick, so requester 0 wins first after reset.
module rr_arbiter import counter_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               areset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [ID_W-1:0]    grant_id_o
);

  logic [ID_W-1:0] last_q, last_d;

  assign valid_o    = |req_i;
  assign grant_id_o = ID_W'(rr_pick(MAX_REQ'(req_i), PICK_W'(last_q), NUM_REQ));
  assign grant_oh_o = valid_o ? (NUM_REQ'(1) << grant_id_o) : '0;

  always_comb begin
    last_d = last_q;
    if (accept_i && valid_o) begin
      last_d = grant_id_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      last_q <= ID_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/counter_burst_scheduler.sv
// Round-robin burst scheduler sharing one free-running counter between NUM_REQ requesters.
// CSCHED_STATS_EN adds completed-burst and delivered-beat counters.
module counter_burst_scheduler import counter_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                      clk,
  input logic                      areset,
  counter_burst_scheduler_if.slave bus
);

  sched_state_e        state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                ctrReady_q, ctrReady_d;
  logic                outValid_q, outValid_d;
  logic [DATA_W-1:0]   outData_q, outData_d;
  logic [ID_W-1:0]     outId_q, outId_d;
  logic [LEN_W-1:0]    issueCnt_q, issueCnt_d;
  logic [LEN_W-1:0]    beatCnt_q, beatCnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ID_W-1:0]     id_q, id_d;

  logic                arbValid;
  logic                arbAccept;
  logic [NUM_REQ-1:0]  arbOh;
  logic [ID_W-1:0]     arbId;
  logic [LEN_W-1:0]    selLen;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk        (clk),
    .areset     (areset),
    .req_i      (bus.req),
    .accept_i   (arbAccept),
    .valid_o    (arbValid),
    .grant_oh_o (arbOh),
    .grant_id_o (arbId)
  );

  assign selLen = bus.req_len[int'(arbId)*LEN_W +: LEN_W];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    ctrReady_d = ctrReady_q;
    issueCnt_d = issueCnt_q;
    beatCnt_d  = beatCnt_q;
    len_d      = len_q;
    id_d       = id_q;
    outValid_d = 1'b0;
    outData_d  = outData_q;
    outId_d    = outId_q;
    arbAccept  = 1'b0;

    case (state_q)
      IDLE: begin
        ctrReady_d = 1'b0;
        if (arbValid) begin
          arbAccept  = 1'b1;
          id_d       = arbId;
          len_d      = selLen;
          grant_d    = arbOh;
          issueCnt_d = '0;
          beatCnt_d  = '0;
          // A zero-length burst skips the counter entirely and completes at once.
          if (selLen == '0) begin
            state_d = DONE;
            done_d  = arbOh;
          end else begin
            state_d    = RUN;
            ctrReady_d = 1'b1;
          end
        end
      end
      RUN: begin
        issueCnt_d = issueCnt_q + LEN_W'(1);
        if (issueCnt_q == len_q - LEN_W'(1)) begin
          ctrReady_d = 1'b0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (beatCnt_q == len_q) begin
          state_d = DONE;
          done_d  = grant_q;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Counter valid is only meaningful while a burst is in flight.
    if ((state_q == RUN || state_q == DRAIN) && bus.ctr_valid) begin
      outValid_d = 1'b1;
      outData_d  = bus.ctr_count;
      outId_d    = id_q;
      beatCnt_d  = beatCnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      ctrReady_q <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outId_q    <= '0;
      issueCnt_q <= '0;
      beatCnt_q  <= '0;
      len_q      <= '0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      ctrReady_q <= ctrReady_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outId_q    <= outId_d;
      issueCnt_q <= issueCnt_d;
      beatCnt_q  <= beatCnt_d;
      len_q      <= len_d;
      id_q       <= id_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.ctr_ready = ctrReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_id    = outId_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef CSCHED_STATS_EN
  logic [31:0] statBursts_q, statBursts_d;
  logic [31:0] statBeats_q, statBeats_d;

  // Counts track the done pulse and out_valid so they update in the same cycle those appear.
  always_comb begin
    statBursts_d = statBursts_q + ((|done_d) ? 32'd1 : 32'd0);
    statBeats_d  = statBeats_q + (outValid_d ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      statBursts_q <= '0;
      statBeats_q  <= '0;
    end else begin
      statBursts_q <= statBursts_d;
      statBeats_q  <= statBeats_d;
    end
  end

  assign bus.stat_bursts = statBursts_q;
  assign bus.stat_beats  = statBeats_q;
`endif

endmodule
